// File: rtl/rc4_encrypt_if.sv
// Bus between the RC4 encryptor and its surroundings: start/ready handshake,
// key, plaintext read port, ciphertext write port and state-array RAM port.
interface rc4_encrypt_if;
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic [7:0]  pt_addr;
    logic [7:0]  pt_rddata;
    logic [7:0]  ct_addr;
    logic [7:0]  ct_wrdata;
    logic        ct_wren;
    logic [7:0]  s_addr;
    logic [7:0]  s_wrdata;
    logic        s_wren;
    logic [7:0]  s_rddata;

    modport slave (
        input  en, key, pt_rddata, s_rddata,
        output rdy, pt_addr, ct_addr, ct_wrdata, ct_wren, s_addr, s_wrdata, s_wren
    );

    modport master (
        output en, key, pt_rddata, s_rddata,
        input  rdy, pt_addr, ct_addr, ct_wrdata, ct_wren, s_addr, s_wrdata, s_wren
    );
endinterface

// File: rtl/rc4_encrypt.sv
// RC4 encryptor: initialises the external S RAM, runs the key schedule with a
// 24-bit key, then encrypts a length-prefixed plaintext into a length-prefixed
// ciphertext. Both RAMs have registered addresses and 1-cycle read latency, so
// each read is issued two edges before its data is consumed; the next S[i+1]
// is prefetched during a swap and forwarded when the swap just overwrote it.
module rc4_encrypt (
    input  logic         clk,
    input  logic         rst_n,
    rc4_encrypt_if.slave bus
);

    typedef enum logic [2:0] {IDLE, INIT, KSA, RDLEN, PRGA, DONE} state_t;

    state_t      state_q;
    logic [2:0]  phase_q;
    logic [7:0]  i_q;
    logic [7:0]  j_q;
    logic [7:0]  si_q;
    logic [7:0]  sj_q;
    logic [7:0]  t_q;
    logic [7:0]  pt_q;
    logic [7:0]  len_q;
    logic [1:0]  keySel_q;
    logic [23:0] key_q;
    logic        rdy_q;
    logic        ctWren_q;
    logic        sWren_q;
    logic [7:0]  ptAddr_q;
    logic [7:0]  ctAddr_q;
    logic [7:0]  ctWrdata_q;
    logic [7:0]  sAddr_q;
    logic [7:0]  sWrdata_q;

    logic [7:0]  keyByte_d;
    logic [7:0]  iNext_d;
    logic [7:0]  jKsa_d;
    logic [7:0]  jPrga_d;
    logic [7:0]  siNext_d;
    logic [7:0]  ks_d;

    assign bus.rdy       = rdy_q;
    assign bus.pt_addr   = ptAddr_q;
    assign bus.ct_addr   = ctAddr_q;
    assign bus.ct_wrdata = ctWrdata_q;
    assign bus.ct_wren   = ctWren_q;
    assign bus.s_addr    = sAddr_q;
    assign bus.s_wrdata  = sWrdata_q;
    assign bus.s_wren    = sWren_q;

    // Index arithmetic plus forwarding of values the RAM read cannot see yet.
    always_comb begin
        keyByte_d = key_q[7:0];
        case (keySel_q)
            2'd0:    keyByte_d = key_q[23:16];
            2'd1:    keyByte_d = key_q[15:8];
            default: keyByte_d = key_q[7:0];
        endcase
        iNext_d  = i_q + 8'd1;
        jKsa_d   = j_q + si_q + keyByte_d;
        jPrga_d  = j_q + si_q;
        siNext_d = (j_q == iNext_d) ? si_q : bus.s_rddata;
        ks_d     = (t_q == i_q) ? sj_q : bus.s_rddata;
    end

    // Control FSM with registered RAM strobes, addresses and write data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            phase_q    <= 3'd0;
            i_q        <= 8'd0;
            j_q        <= 8'd0;
            si_q       <= 8'd0;
            sj_q       <= 8'd0;
            t_q        <= 8'd0;
            pt_q       <= 8'd0;
            len_q      <= 8'd0;
            keySel_q   <= 2'd0;
            key_q      <= 24'd0;
            rdy_q      <= 1'b1;
            ctWren_q   <= 1'b0;
            sWren_q    <= 1'b0;
            ptAddr_q   <= 8'd0;
            ctAddr_q   <= 8'd0;
            ctWrdata_q <= 8'd0;
            sAddr_q    <= 8'd0;
            sWrdata_q  <= 8'd0;
        end else begin
            ctWren_q <= 1'b0;
            sWren_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.en) begin
                        key_q     <= bus.key;
                        rdy_q     <= 1'b0;
                        state_q   <= INIT;
                        i_q       <= 8'd0;
                        sAddr_q   <= 8'd0;
                        sWrdata_q <= 8'd0;
                        sWren_q   <= 1'b1;
                    end
                end
                INIT: begin
                    if (i_q == 8'd255) begin
                        state_q  <= KSA;
                        phase_q  <= 3'd4;
                        sAddr_q  <= 8'd0;
                        i_q      <= 8'd0;
                        j_q      <= 8'd0;
                        keySel_q <= 2'd0;
                    end else begin
                        i_q       <= iNext_d;
                        sAddr_q   <= iNext_d;
                        sWrdata_q <= iNext_d;
                        sWren_q   <= 1'b1;
                    end
                end
                KSA: begin
                    case (phase_q)
                        3'd4: phase_q <= 3'd5;
                        3'd5: begin
                            si_q    <= bus.s_rddata;
                            phase_q <= 3'd0;
                        end
                        3'd0: begin
                            j_q     <= jKsa_d;
                            sAddr_q <= jKsa_d;
                            phase_q <= 3'd1;
                        end
                        3'd1: begin
                            sAddr_q <= iNext_d;
                            phase_q <= 3'd2;
                        end
                        3'd2: begin
                            sj_q      <= bus.s_rddata;
                            sAddr_q   <= j_q;
                            sWrdata_q <= si_q;
                            sWren_q   <= 1'b1;
                            phase_q   <= 3'd3;
                        end
                        default: begin
                            si_q      <= siNext_d;
                            sAddr_q   <= i_q;
                            sWrdata_q <= sj_q;
                            sWren_q   <= 1'b1;
                            i_q       <= iNext_d;
                            keySel_q  <= (keySel_q == 2'd2) ? 2'd0 : keySel_q + 2'd1;
                            phase_q   <= 3'd0;
                            if (i_q == 8'd255) begin
                                state_q  <= RDLEN;
                                ptAddr_q <= 8'd0;
                            end
                        end
                    endcase
                end
                RDLEN: begin
                    case (phase_q)
                        3'd0: begin
                            sAddr_q <= 8'd1;
                            phase_q <= 3'd1;
                        end
                        3'd1: begin
                            len_q      <= bus.pt_rddata;
                            ctAddr_q   <= 8'd0;
                            ctWrdata_q <= bus.pt_rddata;
                            ctWren_q   <= 1'b1;
                            phase_q    <= 3'd2;
                        end
                        default: begin
                            si_q    <= bus.s_rddata;
                            i_q     <= 8'd1;
                            j_q     <= 8'd0;
                            phase_q <= 3'd0;
                            state_q <= (len_q == 8'd0) ? DONE : PRGA;
                        end
                    endcase
                end
                PRGA: begin
                    case (phase_q)
                        3'd0: begin
                            j_q      <= jPrga_d;
                            sAddr_q  <= jPrga_d;
                            ptAddr_q <= i_q;
                            phase_q  <= 3'd1;
                        end
                        3'd1: begin
                            sAddr_q <= iNext_d;
                            phase_q <= 3'd2;
                        end
                        3'd2: begin
                            sj_q      <= bus.s_rddata;
                            t_q       <= si_q + bus.s_rddata;
                            pt_q      <= bus.pt_rddata;
                            sAddr_q   <= j_q;
                            sWrdata_q <= si_q;
                            sWren_q   <= 1'b1;
                            phase_q   <= 3'd3;
                        end
                        3'd3: begin
                            si_q    <= siNext_d;
                            sAddr_q <= t_q;
                            phase_q <= 3'd4;
                        end
                        3'd4: begin
                            sAddr_q   <= i_q;
                            sWrdata_q <= sj_q;
                            sWren_q   <= 1'b1;
                            phase_q   <= 3'd5;
                        end
                        3'd5: begin
                            ctAddr_q   <= i_q;
                            ctWrdata_q <= pt_q ^ ks_d;
                            ctWren_q   <= 1'b1;
                            if (i_q == len_q) begin
                                phase_q <= 3'd6;
                            end else begin
                                i_q     <= iNext_d;
                                phase_q <= 3'd0;
                            end
                        end
                        default: begin
                            phase_q <= 3'd0;
                            state_q <= DONE;
                        end
                    endcase
                end
                DONE: begin
                    rdy_q   <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    rdy_q   <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_encrypt.sv
// Self-checking bench for rc4_encrypt: models the plaintext, ciphertext and
// S RAMs, and compares each run with a plain RC4 reference computed here.
module tb_rc4_encrypt;

    logic clk;
    logic rst_n;

    rc4_encrypt_if bus ();

    rc4_encrypt dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] ptMem [256];
    logic [7:0] ctMem [256];
    logic [7:0] sMem  [256];
    logic [7:0] expCt [256];
    logic [7:0] ptRd;
    logic [7:0] sRd;

    int checks = 0;
    int errors = 0;
    int ctWrites = 0;
    int orderErrs = 0;
    int overErrs = 0;
    int idleStrobeErrs = 0;
    logic [7:0] lastCtAddr = 8'd0;

    assign bus.pt_rddata = ptRd;
    assign bus.s_rddata  = sRd;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAMs (read returns old data) plus ciphertext write bookkeeping.
    always @(posedge clk) begin
        ptRd <= ptMem[bus.pt_addr];
        sRd  <= sMem[bus.s_addr];
        if (bus.s_wren) sMem[bus.s_addr] <= bus.s_wrdata;
        if (bus.ct_wren) begin
            ctMem[bus.ct_addr] <= bus.ct_wrdata;
            ctWrites <= ctWrites + 1;
            lastCtAddr <= bus.ct_addr;
            if (bus.ct_addr != 8'd0 && bus.ct_addr != lastCtAddr + 8'd1)
                orderErrs <= orderErrs + 1;
            if (bus.ct_addr > ptMem[0])
                overErrs <= overErrs + 1;
        end
    end

    // Strobes must stay low whenever the block reports idle.
    always @(negedge clk) begin
        if (rst_n && bus.rdy && (bus.ct_wren || bus.s_wren))
            idleStrobeErrs <= idleStrobeErrs + 1;
    end

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
                   tag, observed, observed, expected, expected);
        end
    endtask

    // Textbook RC4 over the current plaintext memory, written with plain arithmetic.
    task automatic computeRef(input logic [23:0] k);
        int s [256];
        int kb [3];
        int i, j, tmp, len;
        kb[0] = int'(k[23:16]);
        kb[1] = int'(k[15:8]);
        kb[2] = int'(k[7:0]);
        for (int x = 0; x < 256; x++) s[x] = x;
        j = 0;
        for (int x = 0; x < 256; x++) begin
            j = (j + s[x] + kb[x % 3]) % 256;
            tmp = s[x]; s[x] = s[j]; s[j] = tmp;
        end
        len = int'(ptMem[0]);
        expCt[0] = ptMem[0];
        i = 0;
        j = 0;
        for (int n = 1; n <= len; n++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            tmp = s[i]; s[i] = s[j]; s[j] = tmp;
            expCt[n] = ptMem[n] ^ 8'(s[(s[i] + s[j]) % 256]);
        end
    endtask

    task automatic loadPlaintext();
        string msg;
        msg = "Plaintext";
        ptMem[0] = 8'd9;
        for (int x = 0; x < 9; x++) ptMem[x + 1] = msg[x];
    endtask

    task automatic loadRandom(input int len, input bit printable);
        ptMem[0] = 8'(len);
        for (int x = 1; x <= len; x++)
            ptMem[x] = printable ? 8'($urandom_range(126, 32)) : 8'($urandom);
    endtask

    // Compare the ciphertext memory and write statistics against the reference.
    task automatic checkRun(input string tag, input logic [23:0] k, input int w0,
                            input int o0, input int v0);
        int len, mism;
        len = int'(ptMem[0]);
        computeRef(k);
        mism = 0;
        for (int n = 0; n <= len; n++)
            if (ctMem[n] !== expCt[n]) mism++;
        checkOutput({tag, ".ctBytes"}, mism, 0);
        checkOutput({tag, ".ctWrites"}, ctWrites - w0, len + 1);
        checkOutput({tag, ".ctOrder"}, orderErrs - o0, 0);
        checkOutput({tag, ".ctBound"}, overErrs - v0, 0);
    endtask

    // One encryption: start with en, wait (bounded) for rdy, then check results.
    task automatic applyStimulus(input string tag, input logic [23:0] k, input bit holdEn);
        int len, limit, cycles, w0, o0, v0;
        len = int'(ptMem[0]);
        limit = 256 + 1300 + 6 * len;
        w0 = ctWrites;
        o0 = orderErrs;
        v0 = overErrs;
        @(negedge clk);
        bus.key = k;
        bus.en  = 1'b1;
        @(negedge clk);
        if (!holdEn) bus.en = 1'b0;
        checkOutput({tag, ".accepted"}, int'(bus.rdy), 0);
        cycles = 1;
        while (bus.rdy !== 1'b1 && cycles < limit + 10) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, ".rdyBack"}, int'(bus.rdy), 1);
        checkOutput({tag, ".budget"}, int'(cycles <= limit), 1);
        checkRun(tag, k, w0, o0, v0);
    endtask

    initial begin
        logic [7:0] kat [10];
        logic [23:0] rkey;
        int mism, w0, o0, v0, waitCycles;

        kat = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        for (int x = 0; x < 256; x++) begin
            ptMem[x] = 8'd0;
        end
        bus.en  = 1'b0;
        bus.key = 24'd0;
        rst_n   = 1'b1;

        // Reset values while rst_n is low.
        #3 rst_n = 1'b0;
        #1;
        checkOutput("reset.rdy", int'(bus.rdy), 1);
        checkOutput("reset.strobes", int'({bus.ct_wren, bus.s_wren}), 0);
        checkOutput("reset.addrs", int'({bus.pt_addr, bus.ct_addr, bus.s_addr}), 0);
        checkOutput("reset.wrdata", int'({bus.ct_wrdata, bus.s_wrdata}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle with en low: stays ready, nothing written.
        repeat (10) @(negedge clk);
        checkOutput("idle.rdy", int'(bus.rdy), 1);
        checkOutput("idle.strobes", idleStrobeErrs, 0);
        checkOutput("idle.ctWrites", ctWrites, 0);

        // Known-answer vector.
        loadPlaintext();
        applyStimulus("kat", 24'h4B6579, 1'b0);
        mism = 0;
        for (int n = 0; n < 10; n++)
            if (ctMem[n] !== kat[n]) mism++;
        checkOutput("kat.vector", mism, 0);

        // Empty message: only the length byte is written.
        loadRandom(0, 1'b0);
        applyStimulus("len0", 24'h000001, 1'b0);

        // 52-byte printable message with key 000001.
        loadRandom(52, 1'b1);
        applyStimulus("len52", 24'h000001, 1'b0);

        // Random keys and lengths.
        for (int r = 0; r < 3; r++) begin
            rkey = 24'($urandom);
            loadRandom($urandom_range(40, 1), 1'b0);
            applyStimulus("rand", rkey, 1'b0);
        end

        // Abort a run during the key schedule, then rerun the known-answer vector.
        loadRandom(20, 1'b0);
        @(negedge clk);
        bus.key = 24'($urandom);
        bus.en  = 1'b1;
        @(negedge clk);
        bus.en  = 1'b0;
        repeat (400) @(negedge clk);
        checkOutput("abort.busy", int'(bus.rdy), 0);
        rst_n = 1'b0;
        #1;
        checkOutput("abort.rdy", int'(bus.rdy), 1);
        checkOutput("abort.strobes", int'({bus.ct_wren, bus.s_wren}), 0);
        checkOutput("abort.saddr", int'(bus.s_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        loadPlaintext();
        applyStimulus("afterAbort", 24'h4B6579, 1'b0);
        mism = 0;
        for (int n = 0; n < 10; n++)
            if (ctMem[n] !== kat[n]) mism++;
        checkOutput("afterAbort.vector", mism, 0);

        // en held high across a maximum-length run: one run per idle visit.
        rkey = 24'($urandom);
        loadRandom(255, 1'b0);
        applyStimulus("len255", rkey, 1'b1);
        @(negedge clk);
        checkOutput("len255.reaccept", int'(bus.rdy), 0);
        bus.en = 1'b0;
        w0 = ctWrites;
        o0 = orderErrs;
        v0 = overErrs;
        waitCycles = 0;
        while (bus.rdy !== 1'b1 && waitCycles < 256 + 1300 + 6 * 255 + 10) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("len255b.rdyBack", int'(bus.rdy), 1);
        checkRun("len255b", rkey, w0, o0, v0);

        repeat (3) @(negedge clk);
        checkOutput("final.idleStrobes", idleStrobeErrs, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
